// File: rtl/hsiao_ecc_dec_pipe.sv
// Hsiao SEC-DED decoder, two-stage pipeline with valid/ready flow control.
// Stage 1 holds the received data and its syndrome. Stage 2 holds the
// corrected data, syndrome and error class, and drives the outputs directly.
// Saturating counters track corrected and uncorrectable words as they leave.

package hsiao_ecc_pkg;

    localparam int MaxData  = 1024;
    localparam int MaxProt  = 16;
    localparam int MaxTotal = MaxData + MaxProt;

    // Column j of H is hsiao_mat_t[j]; only the low prot_width bits are used.
    typedef logic [MaxTotal-1:0][MaxProt-1:0] hsiao_mat_t;

    // Data columns take odd-weight (>= 3) patterns, lowest weight first and
    // ascending value within a weight. Check-bit columns are unit vectors, so
    // every column is odd and distinct: even syndromes are always double errors.
    function automatic hsiao_mat_t hsiao_matrix(input int data_width, input int prot_width);
        hsiao_mat_t mat;
        int         col;
        int         wt;
        logic [31:0] val;
        mat = '0;
        col = 0;
        for (int w = 3; w <= prot_width; w += 2) begin
            for (int v = 1; v < (1 << prot_width); v++) begin
                val = v;
                wt  = $countones(val);
                if (wt == w && col < data_width) begin
                    mat[col] = val[MaxProt-1:0];
                    col++;
                end
            end
        end
        for (int i = 0; i < prot_width; i++) begin
            mat[data_width + i]    = '0;
            mat[data_width + i][i] = 1'b1;
        end
        return mat;
    endfunction

endpackage

module hsiao_ecc_dec_pipe #(
    parameter int DataWidth  = 32,
    parameter int ProtWidth  = $clog2(DataWidth) + 2,
    parameter int TotalWidth = DataWidth + ProtWidth,
    parameter int CntWidth   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [TotalWidth-1:0] in_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DataWidth-1:0]  out_o,
    output logic [ProtWidth-1:0]  syndrome_o,
    output logic [1:0]            err_o,
    input  logic                  clear_cnt_i,
    output logic [CntWidth-1:0]   corr_cnt_o,
    output logic [CntWidth-1:0]   uncorr_cnt_o
);

    if (ProtWidth < $clog2(DataWidth) + 2) begin : g_prot_too_small
        $error("hsiao_ecc_dec_pipe: ProtWidth too small for DataWidth");
    end
    if (DataWidth > hsiao_ecc_pkg::MaxData || ProtWidth > hsiao_ecc_pkg::MaxProt) begin : g_too_wide
        $error("hsiao_ecc_dec_pipe: width exceeds hsiao_ecc_pkg limits");
    end

    localparam hsiao_ecc_pkg::hsiao_mat_t HMat =
        hsiao_ecc_pkg::hsiao_matrix(DataWidth, ProtWidth);

    // Stage 1 keeps only the data half of the codeword: the check bits are
    // fully represented by the syndrome from here on.
    logic                 s1_valid_q, s1_valid_d;
    logic [DataWidth-1:0] s1_data_q,  s1_data_d;
    logic [ProtWidth-1:0] s1_syn_q,   s1_syn_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [DataWidth-1:0] s2_data_q,  s2_data_d;
    logic [ProtWidth-1:0] s2_syn_q,   s2_syn_d;
    logic [1:0]           s2_err_q,   s2_err_d;

    logic [CntWidth-1:0]  corr_cnt_q,   corr_cnt_d;
    logic [CntWidth-1:0]  uncorr_cnt_q, uncorr_cnt_d;

    logic                 s1_ready;
    logic                 s2_ready;
    logic                 out_hs;
    logic [ProtWidth-1:0] syn_in;
    logic [DataWidth-1:0] flip_mask;
    logic                 chk_hit;
    logic                 any_hit;
    logic [1:0]           err_cls;
    logic [DataWidth-1:0] data_fixed;

    // Ready chain: a stage can load when empty or when it drains this cycle.
    always_comb begin
        s2_ready   = !s2_valid_q || out_ready_i;
        s1_ready   = !s1_valid_q || s2_ready;
        in_ready_o = s1_ready;
        out_hs     = s2_valid_q && out_ready_i;
    end

    // Syndrome of the incoming codeword: each bit is the parity of one H row.
    always_comb begin
        syn_in = '0;
        for (int i = 0; i < ProtWidth; i++) begin
            for (int j = 0; j < TotalWidth; j++) begin
                if (HMat[j][i]) begin
                    syn_in[i] = syn_in[i] ^ in_i[j];
                end
            end
        end
    end

    // Match the stage-1 syndrome against every column and classify the error.
    always_comb begin
        flip_mask = '0;
        chk_hit   = 1'b0;
        for (int j = 0; j < DataWidth; j++) begin
            flip_mask[j] = (s1_syn_q == HMat[j][ProtWidth-1:0]);
        end
        for (int i = 0; i < ProtWidth; i++) begin
            if (s1_syn_q == HMat[DataWidth + i][ProtWidth-1:0]) begin
                chk_hit = 1'b1;
            end
        end
        any_hit = chk_hit || (|flip_mask);
        if (s1_syn_q == '0) begin
            err_cls = 2'b00;
        end else if ((^s1_syn_q) && any_hit) begin
            err_cls = 2'b01;
        end else begin
            // Even weight, or odd weight aliasing no column: not correctable.
            err_cls = 2'b10;
        end
        data_fixed = (err_cls == 2'b01) ? (s1_data_q ^ flip_mask) : s1_data_q;
    end

    // Next-state for both pipeline stages.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_syn_d   = s1_syn_q;
        if (s1_ready) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_data_d = in_i[DataWidth-1:0];
                s1_syn_d  = syn_in;
            end
        end

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_syn_d   = s2_syn_q;
        s2_err_d   = s2_err_q;
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = data_fixed;
                s2_syn_d  = s1_syn_q;
                s2_err_d  = err_cls;
            end
        end
    end

    // Saturating counters, bumped once per output handshake; clear wins.
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (clear_cnt_i) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_hs) begin
            if (s2_err_q[0] && !(&corr_cnt_q)) begin
                corr_cnt_d = corr_cnt_q + CntWidth'(1);
            end
            if (s2_err_q[1] && !(&uncorr_cnt_q)) begin
                uncorr_cnt_d = uncorr_cnt_q + CntWidth'(1);
            end
        end
    end

    // Pipeline and counter registers; reset discards any in-flight words.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_syn_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_syn_q     <= '0;
            s2_err_q     <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_syn_q     <= s1_syn_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_syn_q     <= s2_syn_d;
            s2_err_q     <= s2_err_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid_o  = s2_valid_q;
    assign out_o        = s2_data_q;
    assign syndrome_o   = s2_syn_q;
    assign err_o        = s2_err_q;
    assign corr_cnt_o   = corr_cnt_q;
    assign uncorr_cnt_o = uncorr_cnt_q;

endmodule

// File: tb/tb_hsiao_ecc_dec_pipe.sv
// Directed bench for hsiao_ecc_dec_pipe (32 data bits, 7 check bits).
// The H columns below are written out by hand so the encoder here does not
// share code with the design.
module tb_hsiao_ecc_dec_pipe;

    localparam logic [6:0] COLS [32] = '{
        7'd7,  7'd11, 7'd13, 7'd14, 7'd19, 7'd21, 7'd22, 7'd25,
        7'd26, 7'd28, 7'd35, 7'd37, 7'd38, 7'd41, 7'd42, 7'd44,
        7'd49, 7'd50, 7'd52, 7'd56, 7'd67, 7'd69, 7'd70, 7'd73,
        7'd74, 7'd76, 7'd81, 7'd82, 7'd84, 7'd88, 7'd97, 7'd98
    };

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, clear_cnt;
    logic [38:0] in_cw;
    logic [31:0] out_data;
    logic [6:0]  syndrome;
    logic [1:0]  err;
    logic [15:0] corr_cnt, uncorr_cnt;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, clear_cnt4;
    logic [38:0] in_cw4;
    logic [31:0] out_data4;
    logic [6:0]  syndrome4;
    logic [1:0]  err4;
    logic [3:0]  corr_cnt4, uncorr_cnt4;

    int n_checks = 0;
    int n_errors = 0;

    hsiao_ecc_dec_pipe #(.DataWidth(32), .ProtWidth(7), .CntWidth(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_i(in_cw),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_o(out_data),
        .syndrome_o(syndrome), .err_o(err), .clear_cnt_i(clear_cnt),
        .corr_cnt_o(corr_cnt), .uncorr_cnt_o(uncorr_cnt)
    );

    hsiao_ecc_dec_pipe #(.DataWidth(32), .ProtWidth(7), .CntWidth(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid4), .in_ready_o(in_ready4), .in_i(in_cw4),
        .out_valid_o(out_valid4), .out_ready_i(out_ready4), .out_o(out_data4),
        .syndrome_o(syndrome4), .err_o(err4), .clear_cnt_i(clear_cnt4),
        .corr_cnt_o(corr_cnt4), .uncorr_cnt_o(uncorr_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [38:0] enc(input logic [31:0] d);
        logic [6:0] p;
        p = '0;
        for (int j = 0; j < 32; j++) begin
            for (int i = 0; i < 7; i++) begin
                if (COLS[j][i]) p[i] = p[i] ^ d[j];
            end
        end
        return {p, d};
    endfunction

    // One word through the main DUT with out_ready high; checks latency 2.
    task automatic send_one(input string tag, input logic [38:0] cw,
                            input logic [31:0] d, input logic [1:0] e, input logic [6:0] s);
        @(negedge clk);
        in_cw    = cw;
        in_valid = 1'b1;
        #1 chk({tag, "_in_ready"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, out_valid, 1'b0);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_err"}, err, e);
        chk({tag, "_syn"}, syndrome, s);
        @(negedge clk);
        chk({tag, "_drained"}, out_valid, 1'b0);
    endtask

    logic [31:0] sdata [8];
    int          sent, recv;
    logic        hs_in, prev_stall;
    logic [31:0] prev_out;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_cw = '0; out_ready = 1'b1; clear_cnt = 1'b0;
        in_valid4 = 1'b0; in_cw4 = '0; out_ready4 = 1'b1; clear_cnt4 = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_syn", syndrome, 7'h0);
        chk("rst_err", err, 2'b00);
        chk("rst_corr", corr_cnt, 16'h0);
        chk("rst_uncorr", uncorr_cnt, 16'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Clean word
        send_one("t1", enc(32'hDEADBEEF), 32'hDEADBEEF, 2'b00, 7'h00);
        chk("t1_corr", corr_cnt, 16'd0);
        chk("t1_uncorr", uncorr_cnt, 16'd0);

        // Single data-bit and check-bit errors
        send_one("t2a", enc(32'h12345678) ^ (39'd1 << 5), 32'h12345678, 2'b01, 7'h15);
        chk("t2a_corr", corr_cnt, 16'd1);
        send_one("t2b", enc(32'h12345678) ^ (39'd1 << 35), 32'h12345678, 2'b01, 7'h08);
        chk("t2b_corr", corr_cnt, 16'd2);
        chk("t2b_uncorr", uncorr_cnt, 16'd0);

        // Double error: columns 14 ^ 50 = 60
        send_one("t3", enc(32'hA5A5A5A5) ^ (39'd1 << 3) ^ (39'd1 << 17), 32'hA5A7A5AD, 2'b10, 7'h3C);
        chk("t3_uncorr", uncorr_cnt, 16'd1);
        chk("t3_corr", corr_cnt, 16'd2);

        // Triple error aliasing to unused odd pattern 67 ^ 35 ^ 4 = 100
        send_one("t3b", enc(32'h0) ^ (39'd1 << 20) ^ (39'd1 << 10) ^ (39'd1 << 34),
                 32'h00100400, 2'b10, 7'h64);
        chk("t3b_uncorr", uncorr_cnt, 16'd2);

        // Back-to-back stream with a stall window
        for (int i = 0; i < 8; i++) sdata[i] = 32'hC0DE0000 + i * 32'h01010101;
        sent = 0; recv = 0; prev_stall = 1'b0; prev_out = '0;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 2 && cyc <= 6);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_cw    = enc(sdata[sent]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_stall) chk("t4_stall_hold", out_data, prev_out);
            if (cyc == 4) chk("t4_in_ready_full", in_ready, 1'b0);
            hs_in = in_valid & in_ready;
            if (out_valid && out_ready) begin
                chk("t4_order", out_data, sdata[recv]);
                chk("t4_err", err, 2'b00);
                recv++;
            end
            prev_stall = out_valid & !out_ready;
            prev_out   = out_data;
            @(posedge clk);
            if (hs_in) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("t4_recv_count", recv, 8);
        chk("t4_sent_count", sent, 8);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_no_extra", out_valid, 1'b0);
        end

        // Saturation on the 4-bit counter instance
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_valid4 = 1'b1;
            in_cw4    = enc(32'h01000193 * k) ^ (39'd1 << (k % 39));
        end
        @(negedge clk);
        in_valid4 = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_corr_sat", corr_cnt4, 4'd15);
        chk("t5_uncorr", uncorr_cnt4, 4'd0);
        @(negedge clk);
        in_valid4 = 1'b1;
        in_cw4    = enc(32'h0F0F0F0F) ^ (39'd1 << 7);
        @(negedge clk);
        in_valid4 = 1'b0;
        @(negedge clk);
        chk("t5_clr_valid", out_valid4, 1'b1);
        chk("t5_clr_err", err4, 2'b01);
        clear_cnt4 = 1'b1;
        @(negedge clk);
        clear_cnt4 = 1'b0;
        chk("t5_cleared", corr_cnt4, 4'd0);
        @(negedge clk);
        in_valid4 = 1'b1;
        in_cw4    = enc(32'h0F0F0F0F) ^ (39'd1 << 30);
        @(negedge clk);
        in_valid4 = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_after_clear", corr_cnt4, 4'd1);

        // Async reset with two words in flight
        @(negedge clk);
        in_valid = 1'b1;
        in_cw    = enc(32'h11111111);
        @(negedge clk);
        in_cw    = enc(32'h22222222) ^ (39'd1 << 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_inflight", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_corr", corr_cnt, 16'd0);
        chk("t6_rst_uncorr", uncorr_cnt, 16'd0);
        chk("t6_rst_data", out_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_dropped", out_valid, 1'b0);
        send_one("t6_post", enc(32'hCAFEF00D), 32'hCAFEF00D, 2'b00, 7'h00);
        chk("t6_post_corr", corr_cnt, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
